// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: shares one FIR core between NUM_CH deserializer
// channels. A channel is granted, its sample is handed to the FIR over a
// valid/ready handshake, and the channel index is queued so the FIR result
// can be relabelled with the channel it came from.
// Build option: FIR_SCHED_PRIORITY_EN selects strict lowest-index priority
// instead of round-robin arbitration.
module fir_channel_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 24,
  parameter int OUT_W     = 24,
  parameter int TAG_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic [NUM_CH-1:0]             iv_req,
  input  logic [NUM_CH*DATA_W-1:0]      iv_din,
  output logic [NUM_CH-1:0]             ov_grant,
  output logic [DATA_W-1:0]             ov_fir_din,
  output logic                          o_fir_din_valid,
  input  logic                          i_fir_ready,
  input  logic [OUT_W-1:0]              iv_fir_dout,
  input  logic                          i_fir_dout_valid,
  output logic [OUT_W-1:0]              ov_dout,
  output logic [$clog2(NUM_CH)-1:0]     ov_dout_ch,
  output logic                          o_dout_valid,
  output logic [$clog2(TAG_DEPTH):0]    ov_inflight,
  output logic                          o_overflow
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ARB, ISSUE} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     last_ch_q, last_ch_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]   fir_din_q, fir_din_d;
  logic                fir_din_valid_q, fir_din_valid_d;
  logic [OUT_W-1:0]    dout_q, dout_d;
  logic [CH_W-1:0]     dout_ch_q, dout_ch_d;
  logic                dout_valid_q, dout_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic [CH_W-1:0]     tag_mem_q [TAG_DEPTH];

  logic                win_found;
  logic [CH_W-1:0]     win_idx;
  logic                push, pop;

`ifdef FIR_SCHED_PRIORITY_EN
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (iv_req[i]) begin
        win_found = 1'b1;
        win_idx   = CH_W'(i);
      end
    end
  end
`else
  // Round-robin: scan upward from the channel after the last winner, wrapping.
  always_comb begin
    int j;
    logic [CH_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      j = int'(last_ch_q) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      cand = CH_W'(j);
      if (!win_found && iv_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  // Next-state: arbitration/issue FSM plus tag FIFO push/pop bookkeeping.
  always_comb begin
    state_d         = state_q;
    last_ch_d       = last_ch_q;
    grant_d         = '0;
    fir_din_d       = fir_din_q;
    fir_din_valid_d = fir_din_valid_q;
    dout_d          = dout_q;
    dout_ch_d       = dout_ch_q;
    dout_valid_d    = 1'b0;
    overflow_d      = overflow_q;
    push            = 1'b0;
    pop             = 1'b0;

    case (state_q)
      ARB: begin
        // Occupancy is the registered count, so a same-cycle pop never
        // frees a slot for this decision.
        if (win_found && cnt_q < CNT_W'(TAG_DEPTH)) begin
          grant_d[win_idx] = 1'b1;
          fir_din_d        = iv_din[int'(win_idx)*DATA_W +: DATA_W];
          fir_din_valid_d  = 1'b1;
          last_ch_d        = win_idx;
          push             = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        if (i_fir_ready) begin
          fir_din_valid_d = 1'b0;
          state_d         = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    if (i_fir_dout_valid) begin
      if (cnt_q != '0) begin
        pop          = 1'b1;
        dout_d       = iv_fir_dout;
        dout_ch_d    = tag_mem_q[rd_ptr_q];
        dout_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State and registered outputs; everything freezes while i_en is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= ARB;
      last_ch_q       <= CH_W'(NUM_CH - 1);
      grant_q         <= '0;
      fir_din_q       <= '0;
      fir_din_valid_q <= 1'b0;
      dout_q          <= '0;
      dout_ch_q       <= '0;
      dout_valid_q    <= 1'b0;
      cnt_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      overflow_q      <= 1'b0;
    end else if (i_en) begin
      state_q         <= state_d;
      last_ch_q       <= last_ch_d;
      grant_q         <= grant_d;
      fir_din_q       <= fir_din_d;
      fir_din_valid_q <= fir_din_valid_d;
      dout_q          <= dout_d;
      dout_ch_q       <= dout_ch_d;
      dout_valid_q    <= dout_valid_d;
      cnt_q           <= cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      overflow_q      <= overflow_d;
    end
  end

  // Tag storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_en && push) tag_mem_q[wr_ptr_q] <= win_idx;
  end

  assign ov_grant        = grant_q;
  assign ov_fir_din      = fir_din_q;
  assign o_fir_din_valid = fir_din_valid_q;
  assign ov_dout         = dout_q;
  assign ov_dout_ch      = dout_ch_q;
  assign o_dout_valid    = dout_valid_q;
  assign ov_inflight     = cnt_q;
  assign o_overflow      = overflow_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler: the driver applies stimulus at
// the falling edge and steps a queue-based reference model, pushing expected
// grants, results and per-cycle status; a monitor pops and compares after
// each rising edge.
module tb_fir_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int DW     = 24;
  localparam int OW     = 24;
  localparam int DEPTH  = 8;

  logic                 i_clk = 1'b0;
  logic                 i_rst, i_en, i_fir_ready, i_fir_dout_valid;
  logic [NUM_CH-1:0]    iv_req;
  logic [NUM_CH*DW-1:0] iv_din;
  logic [OW-1:0]        iv_fir_dout;
  logic [NUM_CH-1:0]    ov_grant;
  logic [DW-1:0]        ov_fir_din;
  logic                 o_fir_din_valid, o_dout_valid, o_overflow;
  logic [OW-1:0]        ov_dout;
  logic [1:0]           ov_dout_ch;
  logic [3:0]           ov_inflight;

  fir_channel_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DW), .OUT_W(OW), .TAG_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .iv_req(iv_req), .iv_din(iv_din),
    .ov_grant(ov_grant), .ov_fir_din(ov_fir_din), .o_fir_din_valid(o_fir_din_valid),
    .i_fir_ready(i_fir_ready), .iv_fir_dout(iv_fir_dout), .i_fir_dout_valid(i_fir_dout_valid),
    .ov_dout(ov_dout), .ov_dout_ch(ov_dout_ch), .o_dout_valid(o_dout_valid),
    .ov_inflight(ov_inflight), .o_overflow(o_overflow));

  always #5 i_clk = ~i_clk;

  typedef struct { int ch; logic [DW-1:0] data; } grant_t;
  typedef struct { int ch; logic [OW-1:0] val; } res_t;
  typedef struct { int inflight; bit ovf; bit vld; logic [DW-1:0] din;
                   logic [OW-1:0] dout; int dout_ch; } status_t;

  grant_t  gq[$];
  res_t    rq[$];
  status_t sq[$];

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit            m_busy, m_ovf, m_gp, m_rp;
  int            m_last, m_dout_ch;
  int            tagq[$];
  grant_t        m_g;
  res_t          m_r;
  logic [DW-1:0] m_din;
  logic [OW-1:0] m_dout;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NUM_CH-1:0] req);
`ifdef FIR_SCHED_PRIORITY_EN
    for (int i = 0; i < NUM_CH; i++) if (req[i]) return i;
`else
    for (int k = 1; k <= NUM_CH; k++) if (req[(m_last + k) % NUM_CH]) return (m_last + k) % NUM_CH;
`endif
    return -1;
  endfunction

  // Apply one cycle of inputs and advance the model to the next rising edge.
  task automatic step(input bit rst, input bit en, input logic [NUM_CH-1:0] req,
                      input bit rdy, input bit fdv, input logic [OW-1:0] fdo);
    logic [NUM_CH*DW-1:0] din;
    int occ, w;
    din = {$urandom(), $urandom(), $urandom()};
    i_rst = rst; i_en = en; iv_req = req; iv_din = din;
    i_fir_ready = rdy; i_fir_dout_valid = fdv; iv_fir_dout = fdo;
    if (rst) begin
      m_busy = 0; m_ovf = 0; m_gp = 0; m_rp = 0; m_last = NUM_CH - 1;
      m_din = '0; m_dout = '0; m_dout_ch = 0; tagq.delete();
    end else if (!en) begin
      if (m_gp) gq.push_back(m_g);
      if (m_rp) rq.push_back(m_r);
    end else begin
      occ = tagq.size();
      m_rp = 0;
      if (fdv) begin
        if (occ > 0) begin
          m_r.ch = tagq.pop_front(); m_r.val = fdo; m_rp = 1;
          rq.push_back(m_r); m_dout = fdo; m_dout_ch = m_r.ch;
        end else m_ovf = 1;
      end
      m_gp = 0;
      if (!m_busy) begin
        w = pick(req);
        if (w >= 0 && occ < DEPTH) begin
          m_g.ch = w; m_g.data = din[w*DW +: DW]; gq.push_back(m_g);
          tagq.push_back(w); m_busy = 1; m_last = w; m_din = m_g.data; m_gp = 1;
        end
      end else if (rdy) m_busy = 0;
    end
    sq.push_back('{tagq.size(), m_ovf, m_busy, m_din, m_dout, m_dout_ch});
  endtask

  task automatic cyc(input bit rst, input bit en, input logic [NUM_CH-1:0] req,
                     input bit rdy, input bit fdv, input logic [OW-1:0] fdo);
    @(negedge i_clk);
    step(rst, en, req, rdy, fdv, fdo);
  endtask

  // Return every outstanding tag with spaced result pulses.
  task automatic drain();
    for (int i = 0; i < 40 && tagq.size() > 0; i++)
      cyc(0, 1, '0, 1, (i % 2) == 0, OW'($urandom));
    cyc(0, 1, '0, 1, 0, '0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard after each rising edge.
  initial begin
    status_t s;
    grant_t  g;
    res_t    r;
    forever begin
      @(posedge i_clk);
      #1;
      if (sq.size() == 0) chk("status_queue_empty", 1, 0);
      else begin
        s = sq.pop_front();
        chk("inflight", 64'(ov_inflight), 64'(s.inflight));
        chk("overflow", 64'(o_overflow), 64'(s.ovf));
        chk("fir_din_valid", 64'(o_fir_din_valid), 64'(s.vld));
        chk("fir_din", 64'(ov_fir_din), 64'(s.din));
        chk("dout", 64'(ov_dout), 64'(s.dout));
        chk("dout_ch", 64'(ov_dout_ch), 64'(s.dout_ch));
      end
      if (ov_grant != '0 || gq.size() != 0) begin
        if (gq.size() == 0) chk("unexpected_grant", 64'(ov_grant), 0);
        else begin
          g = gq.pop_front();
          chk("grant", 64'(ov_grant), 64'(1) << g.ch);
          chk("grant_data", 64'(ov_fir_din), 64'(g.data));
        end
      end
      if (o_dout_valid || rq.size() != 0) begin
        if (rq.size() == 0) chk("unexpected_dout_valid", 64'(o_dout_valid), 0);
        else begin
          r = rq.pop_front();
          chk("dout_valid", 64'(o_dout_valid), 1);
          chk("result_ch", 64'(ov_dout_ch), 64'(r.ch));
          chk("result_val", 64'(ov_dout), 64'(r.val));
        end
      end
    end
  end

  // Driver: directed phases from the plan, then randomized traffic.
  initial begin
    bit fdv;
    step(1, 1, '0, 0, 0, '0);
    cyc(1, 1, '0, 0, 0, '0);
    // round-robin with all channels requesting
    for (int i = 0; i < 9; i++) cyc(0, 1, 4'hF, 1, 0, '0);
    drain();
    // backpressure on a single channel
    cyc(0, 1, 4'b0100, 0, 0, '0);
    for (int i = 0; i < 4; i++) cyc(0, 1, '0, 0, 0, '0);
    cyc(0, 1, '0, 1, 0, '0);
    cyc(0, 1, '0, 1, 0, '0);
    drain();
    // tag return order ch1, ch3, ch0
    cyc(0, 1, 4'b0010, 1, 0, '0); cyc(0, 1, '0, 1, 0, '0);
    cyc(0, 1, 4'b1000, 1, 0, '0); cyc(0, 1, '0, 1, 0, '0);
    cyc(0, 1, 4'b0001, 1, 0, '0); cyc(0, 1, '0, 1, 0, '0);
    cyc(0, 1, '0, 1, 1, 24'h000011); cyc(0, 1, '0, 1, 0, '0);
    cyc(0, 1, '0, 1, 1, 24'h000033); cyc(0, 1, '0, 1, 0, '0);
    cyc(0, 1, '0, 1, 1, 24'h000000); cyc(0, 1, '0, 1, 0, '0);
    // fill the tag FIFO, then free one slot
    for (int i = 0; i < 20; i++) cyc(0, 1, 4'hF, 1, 0, '0);
    cyc(0, 1, 4'hF, 1, 1, 24'h0000AA);
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'hF, 1, 0, '0);
    drain();
    // overflow on empty FIFO, then reset during ISSUE
    cyc(0, 1, '0, 1, 1, 24'h0000EE);
    cyc(0, 1, '0, 1, 0, '0);
    cyc(0, 1, 4'hF, 0, 0, '0);
    cyc(0, 1, 4'hF, 0, 0, '0);
    cyc(1, 1, 4'hF, 0, 0, '0);
    cyc(0, 1, 4'hF, 1, 0, '0);
    cyc(0, 1, '0, 1, 0, '0);
    cyc(0, 1, '0, 1, 1, 24'h000123);
    // priority-style pattern and clock-enable gaps
    for (int i = 0; i < 12; i++) cyc(0, (i % 3) != 1, 4'b1010, 1, 0, '0);
    drain();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (tagq.size() > 0) fdv = ($urandom_range(0, 2) == 0);
      else fdv = ($urandom_range(0, 99) == 0);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
          NUM_CH'($urandom), $urandom_range(0, 1) == 1, fdv, OW'($urandom));
    end
    drain();
    @(posedge i_clk);
    #2;
    chk("scoreboard_drained", 64'(sq.size() + gq.size() + rq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_channel_scheduler.md
# fir_channel_scheduler

Shares one FIR filter instance between NUM_CH serial input channels. Each channel's deserializer presents a parallel sample. The scheduler grants channels round-robin and issues the granted sample to the FIR with a valid/ready handshake. It tags each issued sample with its channel index in an in-flight FIFO and re-labels FIR results with the originating channel. It sits between the per-channel deserializers and the single FIR core.

## Interface
- NUM_CH, 4, number of requesting channels (2..16)
- DATA_W, 24, sample width into FIR
- OUT_W, 24, FIR result width
- TAG_DEPTH, 8, max samples in flight inside FIR (power of 2)
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_en  in  1  clock enable; when low all registers hold
- iv_req  in  NUM_CH  per-channel sample valid (deserializer o_dout_valid)
- iv_din  in  NUM_CH*DATA_W  packed samples, channel k at [k*DATA_W +: DATA_W]
- ov_grant  out  NUM_CH  one-hot, one-cycle pulse: channel sample accepted (drives deserializer i_ready)
- ov_fir_din  out  DATA_W  sample to FIR
- o_fir_din_valid  out  1  sample to FIR valid
- i_fir_ready  in  1  FIR accepts sample
- iv_fir_dout  in  OUT_W  FIR result
- i_fir_dout_valid  in  1  FIR result valid (single-cycle pulse)
- ov_dout  out  OUT_W  result to downstream
- ov_dout_ch  out  $clog2(NUM_CH)  channel of ov_dout
- o_dout_valid  out  1  result valid, one-cycle pulse
- ov_inflight  out  $clog2(TAG_DEPTH)+1  tag FIFO occupancy
- o_overflow  out  1  sticky error: FIR result arrived with tag FIFO empty

## Operation
- FSM states: ARB, ISSUE. Reset state ARB.
- ARB: if any iv_req bit set and ov_inflight < TAG_DEPTH, select a winner:
  - Search starts at last_ch+1 and wraps modulo NUM_CH.
  - Register one-hot ov_grant, capture the winner's slice into ov_fir_din, set o_fir_din_valid, push winner index into the tag FIFO, set last_ch = winner, go to ISSUE.
  - If no request or the FIFO is full: stay in ARB, ov_grant = 0.
- ISSUE: ov_grant = 0; hold o_fir_din_valid and ov_fir_din stable. On an edge with i_fir_ready = 1, clear o_fir_din_valid and go to ARB.
- Result path: on i_fir_dout_valid with FIFO non-empty:
  - Pop the head tag.
  - Register ov_dout = iv_fir_dout, ov_dout_ch = head, o_dout_valid = 1 for one cycle.
- Result path, FIFO empty: set o_overflow. o_dout_valid stays 0 and no pop occurs.
- Push and pop in the same cycle: both performed, occupancy unchanged. A full FIFO with a simultaneous pop still blocks the grant, because the decision uses the registered occupancy.
- Tag FIFO pointers wrap modulo TAG_DEPTH.
- i_en low: FSM, FIFO, and outputs frozen. Pulses (ov_grant, o_dout_valid) hold their current value.

## Timing
- Reset values:
  - state ARB, last_ch = NUM_CH-1 (channel 0 wins first), FIFO empty.
  - ov_grant = 0, ov_fir_din = 0, o_fir_din_valid = 0.
  - ov_dout = 0, ov_dout_ch = 0, o_dout_valid = 0, ov_inflight = 0, o_overflow = 0.
- Reset mid-operation discards all in-flight tags. FIR results arriving afterwards set o_overflow.
- Request sampled at edge N → ov_grant and o_fir_din_valid high after edge N.
- Earliest FIR transfer is edge N+1; next grant is possible at edge N+2. Peak throughput is one sample per 2 cycles.
- Result latency: i_fir_dout_valid at edge M → o_dout_valid high after edge M.
- ov_inflight is registered: it increments after a grant edge and decrements after a pop edge.

## Configuration
- FIR_SCHED_PRIORITY_EN defined: strict fixed priority, lowest requesting index wins; last_ch is unused.
- FIR_SCHED_PRIORITY_EN undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

## Test plan
- Round-robin fairness: iv_req = 4'b1111 held, i_fir_ready = 1.
  - Grants are ch0, ch1, ch2, ch3, ch0 at 2-cycle spacing.
  - ov_fir_din equals each channel's slice.
- Backpressure: single request on ch2, i_fir_ready = 0 for 5 cycles, then 1.
  - o_fir_din_valid is held for 6 cycles with data stable.
  - Only one grant pulse occurs.
- Tag return: issue ch1, ch3, ch0, then return results 0x000011, 0x000033, 0x000000.
  - ov_dout_ch is 1, 3, 0 in order.
  - o_dout_valid is one cycle after each i_fir_dout_valid.
- Full FIFO: 8 issues with no results.
  - ov_inflight = 8 and no further grants while requests persist.
  - One result pops a tag; grant resumes the following ARB cycle.
- Overflow and reset: result pulse with the FIFO empty → o_overflow = 1, o_dout_valid = 0. Assert i_rst during ISSUE → all outputs return to reset values; next grant goes to ch0.
- FIR_SCHED_PRIORITY_EN build: iv_req = 4'b1010 held → ch1 granted on every arbitration.
